prio_encoder_rr: RTL and testbench

- Parametrised, registered successor to the team's 8-to-3 enable-gated encoder.
- Accepts an N-bit request vector and resolves it to a binary index even when several bits are set, using one of two priority modes:
  - fixed priority: highest index wins;
  - round-robin.
- The result is held in an output register with a valid/ready handshake.
- Sits between request sources (interrupt/arbiter lines) and a downstream consumer that may stall.

---
 rtl/prio_pkg.sv | 25 ++
 rtl/prio_scan.sv | 39 +++
 rtl/prio_encoder_rr.sv | 92 +++++++++
 tb/tb_prio_encoder_rr.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;  // highest set index wins
  localparam logic MODE_RR    = 1'b1;  // rotating scan starting at the pointer

  // Widest request vector the helpers below accept; callers zero-extend.
  localparam int MAX_N = 256;

  // Binary index of the single set bit of a one-hot vector (0 when empty).
  function automatic logic [7:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational winner selection. The scan walks downward from a start
// position and wraps; fixed mode starts at N-1, round-robin at ptr.
module prio_scan
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  int   start;
  int   pos;
  logic found;

  // First set bit in the order start, start-1, ..., 0, N-1, ..., start+1.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    pos    = 0;
    start  = (mode == MODE_RR) ? int'(ptr) : N - 1;
    for (int k = 0; k < N; k++) begin
      pos = (start + N - k) % N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
      end
    end
  end

  assign valid = |req;
  assign idx   = W'(onehot_to_idx(MAX_N'(onehot)));

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with fixed / round-robin modes and a
// valid/ready output stage.
// Handshake: a result is transferred on any clk edge where out_valid and
// out_ready are both 1; while out_valid is 1 and out_ready is 0 every output
// holds. A new result loads whenever the slot is free (empty or being
// accepted) so back-to-back transfers need no bubble.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         scan_valid;
  logic [W-1:0] scan_idx;
  logic [N-1:0] scan_onehot;
  logic         free;
  logic         load;

  prio_scan #(.N(N)) u_scan (
    .req    (req),
    .ptr    (ptr_q),
    .mode   (mode),
    .valid  (scan_valid),
    .idx    (scan_idx),
    .onehot (scan_onehot)
  );

  assign free = !valid_q || out_ready;
  assign load = en && scan_valid && free;

  // Next state: load a new winner, empty an accepted slot, or hold on stall.
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    ptr_d    = ptr_q;
    if (load) begin
      valid_d  = 1'b1;
      idx_d    = scan_idx;
      onehot_d = scan_onehot;
      multi_d  = popcount_gt1(MAX_N'(req));
      // Only round-robin loads move the pointer: next scan starts just below the winner.
      if (mode == MODE_RR) begin
        ptr_d = (scan_idx == '0) ? W'(N - 1) : scan_idx - W'(1);
      end
    end else if (free) begin
      valid_d = 1'b0;
    end
  end

  // Output and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
      ptr_q    <= W'(N - 1);
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: driver predicts each load with a behavioural
// model and queues the expected result; a monitor pops and compares whenever
// the DUT hands a result over.
module tb_prio_encoder_rr;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int EW = W + N + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .en         (en),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_multi  (out_multi)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  m_valid  = 1'b0;   // model: out_valid after the coming edge
  bit  cur_valid = 1'b0;  // model: out_valid visible right now
  int  m_ptr    = N - 1;
  bit  mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference winner: fixed mode takes the highest set bit; round-robin looks
  // at ptr down to 0 first, then N-1 down to ptr+1.
  function automatic int model_winner(input logic [N-1:0] r, input bit rr, input int p);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      return -1;
    end
    for (int i = p; i >= 0; i--) if (r[i]) return i;
    for (int i = N - 1; i > p; i--) if (r[i]) return i;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r_n, input logic [N-1:0] rq, input bit e,
                       input bit md, input bit rdy);
    bit free;
    int w;
    logic [N-1:0] oh;
    @(negedge clk);
    rst_n = r_n; req = rq; en = e; mode = md; out_ready = rdy;
    cur_valid = m_valid;
    if (!r_n) begin
      m_valid = 1'b0;
      m_ptr   = N - 1;
      exp_q.delete();
    end else begin
      free = !m_valid || rdy;
      if (e && rq != '0 && free) begin
        w  = model_winner(rq, md, m_ptr);
        oh = '0;
        oh[w] = 1'b1;
        exp_q.push_back({W'(w), oh, ($countones(rq) > 1)});
        m_valid = 1'b1;
        if (md) m_ptr = (w == 0) ? N - 1 : w - 1;
      end else if (free) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n) begin
        check("out_valid", 32'(out_valid), 32'(cur_valid));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got idx %0d with nothing expected at %0t", out_idx, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_idx",    32'(out_idx),    32'(e[EW-1 -: W]));
            check("out_onehot", 32'(out_onehot), 32'(e[N:1]));
            check("out_multi",  32'(out_multi),  32'(e[0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] r;
    // Reset with all requests high.
    drive(0, 8'hFF, 1, 0, 1);
    drive(0, 8'hFF, 1, 0, 1);
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_idx",    32'(out_idx),    32'd0);
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_multi",  32'(out_multi),  32'd0);

    // Single request -> idx 5.
    drive(1, 8'b0010_0000, 1, 0, 1);
    // Fixed priority, held four cycles.
    repeat (4) drive(1, 8'b1000_1010, 1, 0, 1);
    // Round-robin rotation: 7, 3, 1, 7.
    repeat (4) drive(1, 8'b1000_1010, 1, 1, 1);
    // Backpressure: load 4, stall 5 cycles while req changes, then release.
    drive(1, 8'b0001_0000, 1, 0, 1);
    repeat (5) drive(1, 8'h01, 1, 0, 0);
    drive(1, 8'h01, 1, 0, 1);
    // Enable low: drains, no new loads.
    repeat (3) drive(1, 8'hFF, 0, 0, 1);
    // Zero requests.
    repeat (2) drive(1, 8'h00, 1, 0, 1);
    // Reset mid-operation: move ptr, stall a result, reset, then RR with 0x81.
    drive(1, 8'b0000_1000, 1, 1, 1);
    drive(1, 8'h00, 1, 1, 0);
    drive(0, 8'h00, 1, 1, 0);
    drive(1, 8'b1000_0001, 1, 1, 1);
    drive(1, 8'h00, 1, 1, 1);
    drive(1, 8'h00, 1, 1, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
      drive(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    // Drain.
    repeat (3) drive(1, 8'h00, 1, 0, 1);
    @(negedge clk); #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
